// File: rtl/issue_scoreboard_pkg.sv
// ============================================================================
// Module   : mips_sched_pkg
// Brief    : Shared encodings, default latencies and writeback slot type for
//            the MIPS issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_sched_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MUL  = 2'd1,
        FU_MEM  = 2'd2,
        FU_NONE = 2'd3
    } fu_e;

    localparam int DEF_ALU_LAT  = 1;
    localparam int DEF_MEM_LAT  = 2;
    localparam int DEF_MUL_LAT  = 4;
    localparam int DEF_WB_DEPTH = 8;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [1:0] fu;
    } wb_slot_t;

endpackage

`default_nettype wire

// File: rtl/issue_scoreboard_if.sv
// ============================================================================
// Module   : issue_scoreboard_if
// Brief    : Decode-to-scheduler handshake and writeback schedule bundle.
//            ISSUE_SB_PERF_EN adds the stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface issue_scoreboard_if;

    logic        id_valid;
    logic [1:0]  id_fu;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_fu;
    logic [31:0] pending;
`ifdef ISSUE_SB_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] raw_stalls;
`endif

    modport master (
        output id_valid, id_fu, id_rs, id_rt, id_uses_rt, id_rd, id_we, flush,
        input  stall, issue_fire, wb_valid, wb_rd, wb_fu, pending
`ifdef ISSUE_SB_PERF_EN
        , input stall_cycles, raw_stalls
`endif
    );

    modport slave (
        input  id_valid, id_fu, id_rs, id_rt, id_uses_rt, id_rd, id_we, flush,
        output stall, issue_fire, wb_valid, wb_rd, wb_fu, pending
`ifdef ISSUE_SB_PERF_EN
        , output stall_cycles, raw_stalls
`endif
    );

endinterface

`default_nettype wire

// File: rtl/issue_scoreboard_shifter.sv
// ============================================================================
// Module   : wb_reservation_shifter
// Brief    : Writeback reservation slots; shift toward slot 0 every cycle,
//            with an optional insert at a given index overriding the shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_reservation_shifter
    import mips_sched_pkg::*;
#(
    parameter  int WB_DEPTH = DEF_WB_DEPTH,
    localparam int IDX_W    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                ins_valid_i,
    input  wire logic [IDX_W-1:0]    ins_idx_i,
    input  wire wb_slot_t            ins_slot_i,
    output wb_slot_t                 head_o,
    output logic     [WB_DEPTH-1:0]  occ_o
);

    wb_slot_t slot_q [WB_DEPTH];
    wb_slot_t slot_d [WB_DEPTH];

    always_comb begin
        for (int i = 0; i < WB_DEPTH - 1; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        slot_d[WB_DEPTH-1] = '0;
        if (ins_valid_i) begin
            slot_d[ins_idx_i] = ins_slot_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign head_o = slot_q[0];

    generate
        for (genvar g = 0; g < WB_DEPTH; g++) begin : g_occ
            assign occ_o[g] = slot_q[g].valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// Module   : issue_scoreboard
// Brief    : In-order issue / out-of-order completion scheduler: RAW/WAW,
//            MUL-busy and writeback-port collision checks. ISSUE_SB_PERF_EN
//            adds stall_cycles / raw_stalls counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_scoreboard
    import mips_sched_pkg::*;
#(
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int WB_DEPTH = DEF_WB_DEPTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    issue_scoreboard_if.slave  sb
);

    localparam int IDX_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int LAT_W = $clog2(WB_DEPTH + 1);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    wb_slot_t            head;
    logic [WB_DEPTH-1:0] occ;
    logic [WB_DEPTH:0]   occ_ext;
    logic [31:0]         pending_q, pending_d;
    logic [CNT_W-1:0]    busy_q, busy_d;
    logic [31:0]         bypass, ready;
    logic [LAT_W-1:0]    lat;
    logic                reserve, raw_ok, waw_ok, mul_ok, wb_ok, can_issue;
    logic                fire, stall_w;
    logic                is_mul;
    wb_slot_t            ins_slot;

    // Slot[WB_DEPTH] does not exist; the padded zero means "no collision".
    assign occ_ext = {1'b0, occ};
    assign bypass  = head.valid ? (32'd1 << head.rd) : 32'd0;
    assign ready   = ~pending_q | bypass | 32'd1;
    assign is_mul  = (sb.id_fu == FU_MUL);

    always_comb begin
        lat = LAT_W'(ALU_LAT);
        case (sb.id_fu)
            FU_MUL:  lat = LAT_W'(MUL_LAT);
            FU_MEM:  lat = LAT_W'(MEM_LAT);
            default: lat = LAT_W'(ALU_LAT);
        endcase
    end

    assign reserve   = (sb.id_fu != FU_NONE) && sb.id_we && (sb.id_rd != 5'd0);
    assign raw_ok    = ready[sb.id_rs] && (!sb.id_uses_rt || ready[sb.id_rt]);
    assign waw_ok    = !reserve || ready[sb.id_rd];
    assign mul_ok    = !is_mul || (busy_q == '0);
    assign wb_ok     = !reserve || !occ_ext[lat];
    assign can_issue = raw_ok && waw_ok && mul_ok && wb_ok;

    // Decode is held throughout reset regardless of hazard state.
    assign fire    = sb.id_valid && can_issue && !sb.flush && rst;
    assign stall_w = sb.id_valid && (!can_issue || !rst);

    assign ins_slot.valid = 1'b1;
    assign ins_slot.rd    = sb.id_rd;
    assign ins_slot.fu    = sb.id_fu;

    wb_reservation_shifter #(
        .WB_DEPTH (WB_DEPTH)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .ins_valid_i (fire && reserve),
        .ins_idx_i   (IDX_W'(lat - 1'b1)),
        .ins_slot_i  (ins_slot),
        .head_o      (head),
        .occ_o       (occ)
    );

    // Clear first so a same-register set on this edge takes priority.
    always_comb begin
        pending_d = pending_q;
        if (head.valid) begin
            pending_d[head.rd] = 1'b0;
        end
        if (fire && reserve) begin
            pending_d[sb.id_rd] = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (fire && is_mul) begin
            busy_d = CNT_W'(MUL_LAT - 1);
        end else if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            busy_q    <= '0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign sb.stall      = stall_w;
    assign sb.issue_fire = fire;
    assign sb.wb_valid   = head.valid;
    assign sb.wb_rd      = head.rd;
    assign sb.wb_fu      = head.fu;
    assign sb.pending    = pending_q;

`ifdef ISSUE_SB_PERF_EN
    logic [31:0] stall_cycles_q, raw_stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            raw_stalls_q   <= '0;
        end else begin
            if (stall_w) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall_w && !raw_ok) begin
                raw_stalls_q <= raw_stalls_q + 32'd1;
            end
        end
    end

    assign sb.stall_cycles = stall_cycles_q;
    assign sb.raw_stalls   = raw_stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// Module   : tb_issue_scoreboard
// Brief    : Self-checking bench for issue_scoreboard against a cycle-schedule
//            reference model. ISSUE_SB_PERF_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;

    localparam int ALU_LAT  = 1;
    localparam int MEM_LAT  = 2;
    localparam int MUL_LAT  = 4;
    localparam int WB_DEPTH = 8;
    localparam logic [1:0] C_ALU = 2'd0, C_MUL = 2'd1, C_MEM = 2'd2, C_NONE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    // Reference model: writebacks keyed by the absolute cycle they occupy.
    int sch_rd [int];
    int sch_fu [int];
    int cyc      = 0;
    int mul_next = 0;

    issue_scoreboard_if sb ();

    issue_scoreboard #(
        .ALU_LAT  (ALU_LAT),
        .MEM_LAT  (MEM_LAT),
        .MUL_LAT  (MUL_LAT),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sch_rd.delete();
        sch_fu.delete();
        cyc      = 0;
        mul_next = 0;
    endtask

    // One cycle: drive, check all outputs against the model, advance the model.
    task automatic step(input logic v, input logic [1:0] fu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic we, input logic fl,
                        output logic fired, output logic stalled);
        logic [31:0] e_pend, fut, rdy;
        logic        reserve, can, e_fire, e_stall, e_wbv;
        logic [4:0]  e_wbrd;
        logic [1:0]  e_wbfu;
        int          lat;
        sb.id_valid = v;  sb.id_fu = fu;  sb.id_rs = rs;  sb.id_rt = rt;
        sb.id_uses_rt = urt;  sb.id_rd = rd;  sb.id_we = we;  sb.flush = fl;
        @(negedge clk);
        e_pend = '0;
        fut    = '0;
        for (int k = 0; k <= WB_DEPTH; k++) begin
            if (sch_rd.exists(cyc + k)) begin
                e_pend[sch_rd[cyc + k]] = 1'b1;
                if (k > 0) fut[sch_rd[cyc + k]] = 1'b1;
            end
        end
        rdy     = ~fut | 32'd1;
        lat     = (fu == C_MUL) ? MUL_LAT : (fu == C_MEM) ? MEM_LAT : ALU_LAT;
        reserve = (fu != C_NONE) && we && (rd != 5'd0);
        can     = rdy[rs] && (!urt || rdy[rt]) && (!reserve || rdy[rd])
                  && (fu != C_MUL || cyc >= mul_next)
                  && !(reserve && sch_rd.exists(cyc + lat));
        e_fire  = v && can && !fl;
        e_stall = v && !can;
        e_wbv   = sch_rd.exists(cyc);
        e_wbrd  = e_wbv ? 5'(sch_rd[cyc]) : 5'd0;
        e_wbfu  = e_wbv ? 2'(sch_fu[cyc]) : 2'd0;

        nvec++;
        if (sb.stall !== e_stall) begin
            nerr++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, sb.stall, e_stall);
        end
        nvec++;
        if (sb.issue_fire !== e_fire) begin
            nerr++; $display("FAIL issue_fire cyc=%0d got=%b exp=%b", cyc, sb.issue_fire, e_fire);
        end
        nvec++;
        if (sb.wb_valid !== e_wbv) begin
            nerr++; $display("FAIL wb_valid cyc=%0d got=%b exp=%b", cyc, sb.wb_valid, e_wbv);
        end
        nvec++;
        if (sb.wb_rd !== e_wbrd || sb.wb_fu !== e_wbfu) begin
            nerr++; $display("FAIL wb_rd_fu cyc=%0d got=%0d/%0d exp=%0d/%0d",
                             cyc, sb.wb_rd, sb.wb_fu, e_wbrd, e_wbfu);
        end
        nvec++;
        if (sb.pending !== e_pend) begin
            nerr++; $display("FAIL pending cyc=%0d got=%h exp=%h", cyc, sb.pending, e_pend);
        end
        fired   = sb.issue_fire;
        stalled = sb.stall;

        if (e_fire && reserve) begin
            sch_rd[cyc + lat] = int'(rd);
            sch_fu[cyc + lat] = int'(fu);
        end
        if (e_fire && fu == C_MUL) mul_next = cyc + MUL_LAT;
        sch_rd.delete(cyc);
        sch_fu.delete(cyc);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic f, s;
        for (int i = 0; i < n; i++) step(1'b0, C_NONE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, f, s);
    endtask

    task automatic test_reset();
        logic f, s;
        sb.id_valid = 1'b1; sb.id_fu = C_ALU; sb.id_rs = 5'd1; sb.id_rt = 5'd2;
        sb.id_uses_rt = 1'b1; sb.id_rd = 5'd3; sb.id_we = 1'b1; sb.flush = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (sb.issue_fire !== 1'b0 || sb.stall !== 1'b1) begin
            nerr++; $display("FAIL reset_hs got fire=%b stall=%b exp fire=0 stall=1", sb.issue_fire, sb.stall);
        end
        nvec++;
        if (sb.pending !== 32'd0 || sb.wb_valid !== 1'b0 || sb.wb_rd !== 5'd0 || sb.wb_fu !== 2'd0) begin
            nerr++; $display("FAIL reset_state got pend=%h wbv=%b rd=%0d fu=%0d exp 0", sb.pending, sb.wb_valid, sb.wb_rd, sb.wb_fu);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(1'b1, C_ALU, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, f, s);
        nvec++;
        if (f !== 1'b1) begin
            nerr++; $display("FAIL first_issue got=%b exp=1", f);
        end
        idle(3);
    endtask

    task automatic test_bypass();
        logic f1, f2, s;
        step(1'b1, C_ALU, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, f1, s);
        step(1'b1, C_ALU, 5'd4, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, f2, s);
        nvec++;
        if (f1 !== 1'b1 || f2 !== 1'b1 || s !== 1'b0) begin
            nerr++; $display("FAIL bypass got f1=%b f2=%b stall=%b exp 1 1 0", f1, f2, s);
        end
        idle(3);
    endtask

    task automatic test_mul_dependent();
        logic f, s;
        int   n = 0;
`ifdef ISSUE_SB_PERF_EN
        logic [31:0] sc0, rs0;
        sc0 = sb.stall_cycles;
        rs0 = sb.raw_stalls;
`endif
        step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, f, s);
        f = 1'b0;
        for (int i = 0; i < 10 && !f; i++) begin
            step(1'b1, C_ALU, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, f, s);
            if (s) n++;
        end
        nvec++;
        if (f !== 1'b1 || n != 3) begin
            nerr++; $display("FAIL mul_raw_stalls got fired=%b stalls=%0d exp 1/3", f, n);
        end
`ifdef ISSUE_SB_PERF_EN
        nvec++;
        if (sb.stall_cycles - sc0 !== 32'd3 || sb.raw_stalls - rs0 !== 32'd3) begin
            nerr++; $display("FAIL perf_counters got %0d/%0d exp 3/3", sb.stall_cycles - sc0, sb.raw_stalls - rs0);
        end
`endif
        idle(6);
    endtask

    task automatic test_wb_collision();
        logic f, s;
        int   n = 0;
        step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, f, s);
        idle(1);
        f = 1'b0;
        for (int i = 0; i < 10 && !f; i++) begin
            step(1'b1, C_MEM, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, f, s);
            if (s) n++;
        end
        nvec++;
        if (f !== 1'b1 || n != 1) begin
            nerr++; $display("FAIL wb_collision got fired=%b stalls=%0d exp 1/1", f, n);
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        logic f, s;
        int   n = 0;
        step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, f, s);
        f = 1'b0;
        for (int i = 0; i < 10 && !f; i++) begin
            step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, f, s);
            if (s) n++;
        end
        nvec++;
        if (f !== 1'b1 || n != 3) begin
            nerr++; $display("FAIL mul_b2b got fired=%b stalls=%0d exp 1/3", f, n);
        end
        idle(6);
    endtask

    task automatic test_flush();
        logic f, s;
        step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, f, s);
        step(1'b1, C_ALU, 5'd1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b1, f, s);
        nvec++;
        if (f !== 1'b0 || s !== 1'b0) begin
            nerr++; $display("FAIL flush got fire=%b stall=%b exp 0 0", f, s);
        end
        idle(6);
    endtask

    task automatic test_random();
        logic       f, s;
        logic [1:0] fu = C_ALU;
        logic [4:0] rs = 0, rt = 0, rd = 0;
        logic       v = 0, urt = 0, we = 0;
        s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!s) begin
                v   = ($urandom_range(0, 99) < 85);
                fu  = 2'($urandom_range(0, 3));
                rs  = 5'($urandom_range(0, 7));
                rt  = 5'($urandom_range(0, 7));
                rd  = 5'($urandom_range(0, 7));
                urt = 1'($urandom_range(0, 1));
                we  = ($urandom_range(0, 99) < 80);
            end
            step(v, fu, rs, rt, urt, rd, we, ($urandom_range(0, 99) < 10), f, s);
        end
        idle(6);
    endtask

    task automatic test_async_reset();
        logic f, s;
        step(1'b1, C_MUL, 5'd1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, f, s);
        step(1'b1, C_ALU, 5'd1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, f, s);
        #2;
        rst = 1'b0;
        #1;
        nvec++;
        if (sb.pending !== 32'd0 || sb.wb_valid !== 1'b0 || sb.issue_fire !== 1'b0 || sb.stall !== 1'b1) begin
            nerr++; $display("FAIL async_reset got pend=%h wbv=%b fire=%b stall=%b exp 0 0 0 1",
                             sb.pending, sb.wb_valid, sb.issue_fire, sb.stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        idle(4);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_mul_dependent();
        test_wb_collision();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
